// File: rtl/ctrl_axil_master_if.sv
// AXI4-Lite master bus bundle for the ctrl register exerciser.
// Signal names mirror the m00_axi port naming of the host core.
interface ctrl_axil_master_if;
  logic [31:0] m00_axi_awaddr;
  logic [2:0]  m00_axi_awprot;
  logic        m00_axi_awvalid;
  logic        m00_axi_awready;
  logic [31:0] m00_axi_wdata;
  logic [3:0]  m00_axi_wstrb;
  logic        m00_axi_wvalid;
  logic        m00_axi_wready;
  logic [1:0]  m00_axi_bresp;
  logic        m00_axi_bvalid;
  logic        m00_axi_bready;
  logic [31:0] m00_axi_araddr;
  logic [2:0]  m00_axi_arprot;
  logic        m00_axi_arvalid;
  logic        m00_axi_arready;
  logic [31:0] m00_axi_rdata;
  logic [1:0]  m00_axi_rresp;
  logic        m00_axi_rvalid;
  logic        m00_axi_rready;

  modport master (
    output m00_axi_awaddr, m00_axi_awprot,
    output m00_axi_awvalid,
    input  m00_axi_awready,
    output m00_axi_wdata, m00_axi_wstrb,
    output m00_axi_wvalid,
    input  m00_axi_wready,
    input  m00_axi_bresp, m00_axi_bvalid,
    output m00_axi_bready,
    output m00_axi_araddr, m00_axi_arprot,
    output m00_axi_arvalid,
    input  m00_axi_arready,
    input  m00_axi_rdata, m00_axi_rresp,
    input  m00_axi_rvalid,
    output m00_axi_rready
  );

  modport slave (
    input  m00_axi_awaddr, m00_axi_awprot,
    input  m00_axi_awvalid,
    output m00_axi_awready,
    input  m00_axi_wdata, m00_axi_wstrb,
    input  m00_axi_wvalid,
    output m00_axi_wready,
    output m00_axi_bresp, m00_axi_bvalid,
    input  m00_axi_bready,
    input  m00_axi_araddr, m00_axi_arprot,
    input  m00_axi_arvalid,
    output m00_axi_arready,
    output m00_axi_rdata, m00_axi_rresp,
    output m00_axi_rvalid,
    input  m00_axi_rready
  );
endinterface

// File: rtl/ctrl_axil_master.sv
// AXI4-Lite write/readback exerciser for a small ctrl register file.
// One transaction in flight; all bus outputs come straight from flops.
module ctrl_axil_master #(
  parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h00000000,
  parameter int          C_NUM_REGS           = 4,
  parameter logic [31:0] C_SEED               = 32'h00000001
) (
  input  logic       m00_axi_aclk,
  input  logic       m00_axi_areset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] mismatch_cnt,
  ctrl_axil_master_if.master m00_axi
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FIN
  } state_t;

  localparam logic [3:0] LAST = 4'(C_NUM_REGS - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] idx_nxt;
  logic       aw_ok;
  logic       w_ok;
  logic       last;

  function automatic logic [31:0] addr_of(input logic [3:0] i);
    return C_M_TARGET_BASE_ADDR + {26'd0, i, 2'b00};
  endfunction

  function automatic logic [31:0] data_of(input logic [3:0] i);
    return C_SEED + {28'd0, i};
  endfunction

  assign idx_nxt = idx + 4'd1;
  assign last    = (idx == LAST);

  // A channel counts as finished once its valid has dropped
  // or is being accepted this cycle.
  assign aw_ok = !m00_axi.m00_axi_awvalid || m00_axi.m00_axi_awready;
  assign w_ok  = !m00_axi.m00_axi_wvalid  || m00_axi.m00_axi_wready;

  assign m00_axi.m00_axi_awprot = 3'b000;
  assign m00_axi.m00_axi_arprot = 3'b000;
  assign m00_axi.m00_axi_wstrb  = 4'hF;

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      state                   <= IDLE;
      idx                     <= '0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      error                   <= 1'b0;
      mismatch_cnt            <= '0;
      m00_axi.m00_axi_awaddr  <= '0;
      m00_axi.m00_axi_awvalid <= 1'b0;
      m00_axi.m00_axi_wdata   <= '0;
      m00_axi.m00_axi_wvalid  <= 1'b0;
      m00_axi.m00_axi_bready  <= 1'b0;
      m00_axi.m00_axi_araddr  <= '0;
      m00_axi.m00_axi_arvalid <= 1'b0;
      m00_axi.m00_axi_rready  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state                   <= WR_REQ;
            idx                     <= '0;
            busy                    <= 1'b1;
            error                   <= 1'b0;
            mismatch_cnt            <= '0;
            m00_axi.m00_axi_awaddr  <= addr_of(4'd0);
            m00_axi.m00_axi_wdata   <= data_of(4'd0);
            m00_axi.m00_axi_awvalid <= 1'b1;
            m00_axi.m00_axi_wvalid  <= 1'b1;
          end
        end
        WR_REQ: begin
          if (m00_axi.m00_axi_awvalid && m00_axi.m00_axi_awready)
            m00_axi.m00_axi_awvalid <= 1'b0;
          if (m00_axi.m00_axi_wvalid && m00_axi.m00_axi_wready)
            m00_axi.m00_axi_wvalid <= 1'b0;
          if (aw_ok && w_ok) begin
            state                  <= WR_RESP;
            m00_axi.m00_axi_bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m00_axi.m00_axi_bvalid) begin
            m00_axi.m00_axi_bready <= 1'b0;
            if (m00_axi.m00_axi_bresp != 2'b00)
              error <= 1'b1;
            if (last) begin
              state                   <= RD_REQ;
              idx                     <= '0;
              m00_axi.m00_axi_araddr  <= addr_of(4'd0);
              m00_axi.m00_axi_arvalid <= 1'b1;
            end else begin
              state                   <= WR_REQ;
              idx                     <= idx_nxt;
              m00_axi.m00_axi_awaddr  <= addr_of(idx_nxt);
              m00_axi.m00_axi_wdata   <= data_of(idx_nxt);
              m00_axi.m00_axi_awvalid <= 1'b1;
              m00_axi.m00_axi_wvalid  <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (m00_axi.m00_axi_arready) begin
            state                   <= RD_RESP;
            m00_axi.m00_axi_arvalid <= 1'b0;
            m00_axi.m00_axi_rready  <= 1'b1;
          end
        end
        RD_RESP: begin
          if (m00_axi.m00_axi_rvalid) begin
            m00_axi.m00_axi_rready <= 1'b0;
            if (m00_axi.m00_axi_rdata != data_of(idx)) begin
              error <= 1'b1;
              if (mismatch_cnt != 8'hFF)
                mismatch_cnt <= mismatch_cnt + 8'd1;
            end
            if (m00_axi.m00_axi_rresp != 2'b00)
              error <= 1'b1;
            if (last) begin
              state <= FIN;
              idx   <= '0;
              done  <= 1'b1;
            end else begin
              state                   <= RD_REQ;
              idx                     <= idx_nxt;
              m00_axi.m00_axi_araddr  <= addr_of(idx_nxt);
              m00_axi.m00_axi_arvalid <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_axil_master.sv
// Directed bench for ctrl_axil_master against a small AXI-Lite slave.
// Slave knobs inject awready delay, bad read data, bresp errors, read stall.
module tb_ctrl_axil_master;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] mismatch_cnt;

  ctrl_axil_master_if m ();

  ctrl_axil_master dut (
    .m00_axi_aclk   (clk),
    .m00_axi_areset (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .mismatch_cnt   (mismatch_cnt),
    .m00_axi        (m.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  int   aw_delay = 1;
  logic bad_rd   = 1'b0;
  logic b_err_en = 1'b0;
  logic r_hold   = 1'b0;

  int          aw_cnt;
  logic        aw_got;
  logic        w_got;
  logic [31:0] aw_a;
  logic [31:0] w_d;
  logic [31:0] mem [16];
  logic        aw_hs;
  logic        w_hs;
  logic [31:0] a_eff;
  logic [31:0] d_eff;

  assign m.m00_axi_awready = m.m00_axi_awvalid && (aw_cnt == aw_delay - 1);
  assign m.m00_axi_wready  = m.m00_axi_wvalid;
  assign m.m00_axi_arready = m.m00_axi_arvalid;
  assign m.m00_axi_rresp   = 2'b00;

  assign aw_hs = m.m00_axi_awvalid && m.m00_axi_awready;
  assign w_hs  = m.m00_axi_wvalid && m.m00_axi_wready;
  assign a_eff = aw_hs ? m.m00_axi_awaddr : aw_a;
  assign d_eff = w_hs ? m.m00_axi_wdata : w_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt          <= 0;
      aw_got          <= 1'b0;
      w_got           <= 1'b0;
      aw_a            <= '0;
      w_d             <= '0;
      m.m00_axi_bvalid <= 1'b0;
      m.m00_axi_bresp  <= 2'b00;
      m.m00_axi_rvalid <= 1'b0;
      m.m00_axi_rdata  <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_a   <= m.m00_axi_awaddr;
        aw_cnt <= 0;
      end else if (m.m00_axi_awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (w_hs) begin
        w_got <= 1'b1;
        w_d   <= m.m00_axi_wdata;
      end
      if (!m.m00_axi_bvalid && (aw_got || aw_hs) && (w_got || w_hs)) begin
        m.m00_axi_bvalid <= 1'b1;
        m.m00_axi_bresp  <= (b_err_en && a_eff == 32'h4) ? 2'b10 : 2'b00;
        mem[a_eff[5:2]]  <= d_eff;
        aw_got           <= 1'b0;
        w_got            <= 1'b0;
      end
      if (m.m00_axi_bvalid && m.m00_axi_bready)
        m.m00_axi_bvalid <= 1'b0;
      if (m.m00_axi_arvalid && m.m00_axi_arready && !r_hold) begin
        m.m00_axi_rvalid <= 1'b1;
        m.m00_axi_rdata  <= (bad_rd && m.m00_axi_araddr == 32'h8)
                            ? 32'h0 : mem[m.m00_axi_araddr[5:2]];
      end
      if (m.m00_axi_rvalid && m.m00_axi_rready)
        m.m00_axi_rvalid <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n counts busy cycles up to and including the done cycle
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  int lat;
  int ndone;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #2;
    chk("rst_ctl", {29'd0, busy, done, error}, 32'd0);
    chk("rst_cnt", {24'd0, mismatch_cnt}, 32'd0);
    chk("rst_vld", {27'd0, m.m00_axi_awvalid, m.m00_axi_wvalid,
        m.m00_axi_arvalid, m.m00_axi_bready, m.m00_axi_rready}, 32'd0);
    chk("rst_awaddr", m.m00_axi_awaddr, 32'd0);
    chk("rst_araddr", m.m00_axi_araddr, 32'd0);
    chk("rst_wdata", m.m00_axi_wdata, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // ideal slave: 4 writes + 4 reads + FIN = 17 cycles
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_vld", {30'd0, m.m00_axi_awvalid, m.m00_axi_wvalid}, 32'd3);
    chk("t1_awaddr", m.m00_axi_awaddr, 32'h0);
    chk("t1_wdata", m.m00_axi_wdata, 32'h1);
    chk("t1_wstrb", {28'd0, m.m00_axi_wstrb}, 32'hF);
    chk("t1_prot", {26'd0, m.m00_axi_awprot, m.m00_axi_arprot}, 32'd0);
    wait_done(lat);
    chk("t1_latency", lat, 32'd17);
    chk("t1_error", {31'd0, error}, 32'd0);
    chk("t1_mis", {24'd0, mismatch_cnt}, 32'd0);
    chk("t1_mem0", mem[0], 32'd1);
    chk("t1_mem1", mem[1], 32'd2);
    chk("t1_mem2", mem[2], 32'd3);
    chk("t1_mem3", mem[3], 32'd4);
    tick();
    chk("t1_idle", {30'd0, busy, done}, 32'd0);

    // awready delayed 3 cycles, wready immediate
    aw_delay = 3;
    pulse_start();
    chk("t2_c1_vld", {30'd0, m.m00_axi_awvalid, m.m00_axi_wvalid}, 32'd3);
    tick();
    chk("t2_c2_vld", {30'd0, m.m00_axi_awvalid, m.m00_axi_wvalid}, 32'd2);
    chk("t2_c2_addr", m.m00_axi_awaddr, 32'h0);
    tick();
    chk("t2_c3_vld", {30'd0, m.m00_axi_awvalid, m.m00_axi_wvalid}, 32'd2);
    chk("t2_c3_addr", m.m00_axi_awaddr, 32'h0);
    tick();
    chk("t2_c4_vld", {29'd0, m.m00_axi_awvalid, m.m00_axi_wvalid,
        m.m00_axi_bready}, 32'd1);
    wait_done(lat);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_error", {31'd0, error}, 32'd0);
    aw_delay = 1;
    tick();

    // bad read data at 0x8
    bad_rd = 1'b1;
    pulse_start();
    wait_done(lat);
    chk("t3_mis", {24'd0, mismatch_cnt}, 32'd1);
    chk("t3_error", {31'd0, error}, 32'd1);
    tick();
    tick();
    tick();
    chk("t3_sticky", {23'd0, error, mismatch_cnt}, 32'h101);
    bad_rd = 1'b0;
    pulse_start();
    chk("t3_clear", {23'd0, error, mismatch_cnt}, 32'h0);
    wait_done(lat);
    chk("t3_clean", {23'd0, error, mismatch_cnt}, 32'h0);
    tick();

    // SLVERR on the second write
    b_err_en = 1'b1;
    pulse_start();
    wait_done(lat);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_error", {31'd0, error}, 32'd1);
    chk("t4_mis", {24'd0, mismatch_cnt}, 32'd0);
    b_err_en = 1'b0;
    tick();

    // reset while waiting in RD_RESP
    r_hold = 1'b1;
    pulse_start();
    lat = 0;
    while (!m.m00_axi_rready && lat < 100) begin
      tick();
      lat++;
    end
    chk("t5_in_rd", {31'd0, m.m00_axi_rready}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_out", {25'd0, m.m00_axi_awvalid, m.m00_axi_wvalid,
        m.m00_axi_arvalid, m.m00_axi_bready, m.m00_axi_rready,
        busy, done}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) ndone++;
    end
    rst    = 1'b0;
    r_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("t5_no_done", ndone, 32'd0);
    pulse_start();
    wait_done(lat);
    chk("t5_latency", lat, 32'd17);
    chk("t5_clean", {23'd0, error, mismatch_cnt}, 32'h0);
    tick();

    // start while busy is ignored
    pulse_start();
    tick();
    tick();
    pulse_start();
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("t6_one_done", ndone, 32'd1);
    chk("t6_idle", {30'd0, busy, error}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
